coin_feed_sequencer: RTL
========================

// Module: coin_feed_sequencer
// PURPOSE
//  Front-end controller for the drink machine FSM. Accepts coin events from two requesters
//  (A = front-panel acceptor, B = service/test port), arbitrates them round-robin into a small FIFO,
//  and feeds them to the machine as single-cycle one-hot nickel_in/dime_in/quarter_in pulses with
//  guaranteed spacing. Tracks credit, waits for dispense, checks returned change, counts vends.
// PARAMETERS
//  FIFO_DEPTH    4   coin FIFO entries (power of 2, >=2)
//  GAP_CYCLES    1   idle cycles forced after every coin pulse (>=1)
//  VEND_TIMEOUT  8   cycles allowed in WAIT_VEND for dispense before fault
//  CNT_W         16  width of vend_count
// PORTS
//  clk           in   1      clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  a_valid       in   1      requester A has a coin
//  a_coin        in   2      A coin code: 01 nickel(5), 10 dime(10), 11 quarter(25), 00 invalid
//  a_ready       out  1      A transfer accepted when a_valid & a_ready
//  b_valid       in   1      requester B has a coin
//  b_coin        in   2      B coin code, same encoding
//  b_ready       out  1      B transfer accepted when b_valid & b_ready
//  nickel_in     out  1      one-cycle pulse to machine
//  dime_in       out  1      one-cycle pulse to machine
//  quarter_in    out  1      one-cycle pulse to machine
//  dispense      in   1      machine dispense output
//  nickel_out    in   1      machine change: 5c
//  dime_out      in   1      machine change: 10c
//  two_dime_out  in   1      machine change: 20c
//  fault_clr     in   1      clears fault, returns to IDLE
//  credit        out  7      cents fed since last vend (0..70)
//  change_cents  out  6      change measured at last vend
//  vend_count    out  CNT_W  completed vends, wraps at 2^CNT_W
//  fault         out  1      sticky: timeout or change mismatch
// BEHAVIOUR
//  Reset: all outputs 0 except a_ready=b_ready=1. FIFO flushed, state IDLE, last_grant=B.
//  Reset mid-operation aborts any pulse, gap, or wait immediately.
//  Arbiter: at most one push per cycle. ready derived from registered FIFO count only.
//   If FIFO full, a_ready=b_ready=0, even when a pop occurs the same cycle.
//   If not full and only one valid, that requester gets ready.
//   If both valid, grant the requester not granted last; update last_grant on each transfer.
//   Code 00 is accepted by the handshake, then discarded (never pushed). It still updates last_grant.
//  Issue FSM states:
//   IDLE: if FIFO non-empty, credit<50 and !fault: pop at edge N.
//     The matching pulse is high for exactly cycle N+1, and credit += value at edge N.
//     Then go to GAP.
//   GAP: stays GAP_CYCLES cycles after the pulse cycle. No pulses.
//     Then go to WAIT_VEND if credit>=50, else IDLE.
//   WAIT_VEND: timer counts from 0. On the first cycle with dispense=1:
//     change_cents = 5*nickel_out + 10*dime_out + 20*two_dime_out, sampled same cycle.
//     fault=1 if change_cents != credit-50.
//     credit<=0, vend_count++, go to DRAIN.
//     If timer reaches VEND_TIMEOUT with no dispense: fault=1, go to FAULT.
//   DRAIN: wait until dispense=0, then IDLE (or FAULT if fault set).
//   FAULT: no pops or pulses. FIFO still accepts until full.
//     fault_clr: fault<=0, credit<=0, go to IDLE. fault_clr is ignored in other states.
//  At most one of nickel_in/dime_in/quarter_in is high in any cycle. Never two pulses closer than GAP_CYCLES+1 cycles.
//  Credit max 45+25=70, fits 7 bits. No coin is ever issued while credit>=50.
// TESTING
//  1 Reset: assert reset 2 cycles -> all pulses 0, credit 0, vend_count 0, fault 0, a_ready=b_ready=1.
//  2 A sends quarter, quarter -> two quarter_in pulses 2 cycles apart, credit 25 then 50.
//    Model dispense -> vend_count 1, change_cents 0, credit 0.
//  3 A=dime and B=nickel held valid continuously -> grants A,B,A,B.
//    Pulses dime,nickel,dime,nickel, then credit 30.
//  4 dime x4 + nickel, then quarter -> credit 70; dispense with two_dime_out -> change_cents 20, fault 0.
//    Repeat with nickel_out only -> fault 1.
//  5 Reach credit 50, hold dispense low 8 cycles -> fault 1, no further pulses despite queued coins.
//    fault_clr -> credit 0, pulses resume.
//  6 Push 4 coins while in WAIT_VEND -> ready low on 5th; reset mid-stream -> FIFO empty, no pulse after reset.

Source files
------------

// File: rtl/coin_feed_sequencer.sv
// Two-requester round-robin coin front end feeding one-hot coin pulses to the drink machine.
// Latency: a coin accepted at edge N can pop at edge N+1; its pulse is high for the cycle after the pop.
// Backpressure: both readies drop while the FIFO is full; the machine side is never stalled.
module coin_feed_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP_CYCLES   = 1,
  parameter int VEND_TIMEOUT = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [1:0]       a_coin,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [1:0]       b_coin,
  output logic             b_ready,
  output logic             nickel_in,
  output logic             dime_in,
  output logic             quarter_in,
  input  logic             dispense,
  input  logic             nickel_out,
  input  logic             dime_out,
  input  logic             two_dime_out,
  input  logic             fault_clr,
  output logic [6:0]       credit,
  output logic [5:0]       change_cents,
  output logic [CNT_W-1:0] vend_count,
  output logic             fault
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_FW  = PTR_W + 1;
  localparam int TMR_MAX = (VEND_TIMEOUT > GAP_CYCLES) ? VEND_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [6:0] VEND_PRICE = 7'd50;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Coin code to cents; code 00 never reaches the FIFO.
  function automatic logic [6:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = 7'd5;
      2'b10:   coin_value = 7'd10;
      2'b11:   coin_value = 7'd25;
      default: coin_value = 7'd0;
    endcase
  endfunction

  // Pulse vector ordered {quarter, dime, nickel}.
  function automatic logic [2:0] coin_onehot(input logic [1:0] code);
    case (code)
      2'b01:   coin_onehot = 3'b001;
      2'b10:   coin_onehot = 3'b010;
      2'b11:   coin_onehot = 3'b100;
      default: coin_onehot = 3'b000;
    endcase
  endfunction

  logic [1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0] cnt_q, cnt_d;
  logic              last_a_q;

  state_t            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [6:0]        credit_q;
  logic [2:0]        pulse_q;
  logic [5:0]        change_q;
  logic [CNT_W-1:0]  vend_q;
  logic              fault_q;

  logic              fifo_full, both_vld, a_fire, b_fire, push, pop;
  logic [1:0]        push_coin, head_coin;
  logic [5:0]        meas_change;
  logic [6:0]        expect_change;

  // Readies depend only on the registered occupancy, so a same-cycle pop never opens a slot.
  assign fifo_full = (cnt_q == CNT_FW'(FIFO_DEPTH));
  assign both_vld  = a_valid & b_valid;
  assign a_ready   = ~fifo_full & ~(both_vld & last_a_q);
  assign b_ready   = ~fifo_full & ~(both_vld & ~last_a_q);
  assign a_fire    = a_valid & a_ready;
  assign b_fire    = b_valid & b_ready & ~a_fire;
  assign push_coin = a_fire ? a_coin : b_coin;
  assign push      = (a_fire | b_fire) & (push_coin != 2'b00);

  assign head_coin = mem_q[rd_ptr_q];
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0) && (credit_q < VEND_PRICE) && !fault_q;

  assign meas_change   = (nickel_out   ? 6'd5  : 6'd0)
                       + (dime_out     ? 6'd10 : 6'd0)
                       + (two_dime_out ? 6'd20 : 6'd0);
  assign expect_change = credit_q - VEND_PRICE;

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_FW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_FW'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_coin;
    end
  end

  // FIFO pointers, occupancy and round-robin history (invalid coins still count as a grant).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_a_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (a_fire | b_fire) last_a_q <= a_fire;
    end
  end

  // Issue FSM: pop and pulse, enforce spacing, wait for the vend, verify change, handle faults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      credit_q <= '0;
      pulse_q  <= '0;
      change_q <= '0;
      vend_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      pulse_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            pulse_q  <= coin_onehot(head_coin);
            credit_q <= credit_q + coin_value(head_coin);
            timer_q  <= '0;
            state_q  <= S_GAP;
          end
        end
        // The pulse cycle is the first GAP cycle; the following IDLE cycle is the last quiet one.
        S_GAP: begin
          if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
            timer_q <= '0;
            state_q <= (credit_q >= VEND_PRICE) ? S_WAIT : S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_WAIT: begin
          if (dispense) begin
            change_q <= meas_change;
            if ({1'b0, meas_change} != expect_change) fault_q <= 1'b1;
            credit_q <= '0;
            vend_q   <= vend_q + CNT_W'(1);
            state_q  <= S_DRAIN;
          end else if (timer_q == TMR_W'(VEND_TIMEOUT - 1)) begin
            fault_q <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_DRAIN: begin
          if (!dispense) state_q <= fault_q ? S_FAULT : S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) begin
            fault_q  <= 1'b0;
            credit_q <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nickel_in    = pulse_q[0];
  assign dime_in      = pulse_q[1];
  assign quarter_in   = pulse_q[2];
  assign credit       = credit_q;
  assign change_cents = change_q;
  assign vend_count   = vend_q;
  assign fault        = fault_q;

endmodule
